weight_config_loader: RTL and testbench

Decodes a packetised 32-bit configuration stream (headers plus payload words) into the per-neuron weight/bias load interface that every neuron in the network listens to. It drives the shared `weightValid`/`biasValid`/`weightValue`/`biasValue`/`config_layer_num`/`config_neuron_num` bus with one strobe per accepted payload word. It sits between the host/DMA configuration port and all neuron instances of all layers. It also flags malformed packets and reports load completion.

---
 rtl/weight_config_loader_if.sv | 9 +
 rtl/weight_config_loader.sv | 169 ++++++++++++++++
 tb/tb_weight_config_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/weight_config_loader_if.sv
// Configuration stream port: 32-bit words with valid/ready handshake.
interface weight_config_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/weight_config_loader.sv
// Decodes header+payload config packets into the shared neuron weight/bias load bus.
// One registered strobe per payload word, one cycle after acceptance; s_ready drops only in LOADED/ERROR.
module weight_config_loader #(
  parameter int layerBits  = 6,
  parameter int neuronBits = 10,
  parameter int countBits  = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  weight_config_loader_if.slave       s_if,
  output logic                        weightValid,
  output logic                        biasValid,
  output logic [31:0]                 weightValue,
  output logic [31:0]                 biasValue,
  output logic [31:0]                 config_layer_num,
  output logic [31:0]                 config_neuron_num,
  output logic                        done,
  output logic                        loaded,
  output logic                        err,
  output logic [31:0]                 weight_count
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, LOADED, ERROR} state_t;

  state_t                r_state;
  logic                  r_ready;
  logic [countBits-1:0]  r_cnt;
  logic                  r_is_bias;
  logic                  r_wvld;
  logic                  r_bvld;
  logic [31:0]           r_wval;
  logic [31:0]           r_bval;
  logic [31:0]           r_layer;
  logic [31:0]           r_neuron;
  logic                  r_done;
  logic                  r_loaded;
  logic                  r_err;
  logic [31:0]           r_wcount;

  state_t                w_state_nxt;
  logic [countBits-1:0]  w_cnt_nxt;
  logic                  w_is_bias_nxt;
  logic                  w_accept;
  logic                  w_wstb;
  logic                  w_bstb;
  logic                  w_done;
  logic                  w_hdr_load;
  logic                  w_loaded_set;
  logic                  w_err_set;
  logic [1:0]            w_type;
  logic [layerBits-1:0]  w_layer;
  logic [neuronBits-1:0] w_neuron;
  logic [countBits-1:0]  w_count;

  assign w_accept = s_if.s_valid & r_ready;
  assign w_type   = s_if.s_data[31:30];
  assign w_layer  = s_if.s_data[countBits+neuronBits +: layerBits];
  assign w_neuron = s_if.s_data[countBits +: neuronBits];
  assign w_count  = s_if.s_data[0 +: countBits];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_is_bias_nxt = r_is_bias;
    w_wstb        = 1'b0;
    w_bstb        = 1'b0;
    w_done        = 1'b0;
    w_hdr_load    = 1'b0;
    w_loaded_set  = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_type)
            2'b00: begin
              w_hdr_load = 1'b1;
              if (w_count == '0) begin
                w_done = 1'b1;
              end else begin
                w_state_nxt   = PAYLOAD;
                w_cnt_nxt     = w_count;
                w_is_bias_nxt = 1'b0;
              end
            end
            2'b01: begin
              // Bias packets carry exactly one word regardless of the count field.
              w_hdr_load    = 1'b1;
              w_state_nxt   = PAYLOAD;
              w_cnt_nxt     = countBits'(1);
              w_is_bias_nxt = 1'b1;
            end
            2'b10: begin
              w_state_nxt  = LOADED;
              w_loaded_set = 1'b1;
              w_done       = 1'b1;
            end
            default: begin
              w_state_nxt = ERROR;
              w_err_set   = 1'b1;
            end
          endcase
        end
      end
      PAYLOAD: begin
        if (w_accept) begin
          w_wstb    = ~r_is_bias;
          w_bstb    = r_is_bias;
          w_cnt_nxt = r_cnt - countBits'(1);
          if (r_cnt == countBits'(1)) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_cnt     <= '0;
      r_is_bias <= 1'b0;
      r_wvld    <= 1'b0;
      r_bvld    <= 1'b0;
      r_wval    <= '0;
      r_bval    <= '0;
      r_layer   <= '0;
      r_neuron  <= '0;
      r_done    <= 1'b0;
      r_loaded  <= 1'b0;
      r_err     <= 1'b0;
      r_wcount  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ready   <= (w_state_nxt == IDLE) || (w_state_nxt == PAYLOAD);
      r_cnt     <= w_cnt_nxt;
      r_is_bias <= w_is_bias_nxt;
      r_wvld    <= w_wstb;
      r_bvld    <= w_bstb;
      r_done    <= w_done;
      if (w_wstb) begin
        r_wval   <= s_if.s_data;
        r_wcount <= r_wcount + 32'd1;
      end
      if (w_bstb) r_bval <= s_if.s_data;
      if (w_hdr_load) begin
        r_layer  <= 32'(w_layer);
        r_neuron <= 32'(w_neuron);
      end
      if (w_loaded_set) r_loaded <= 1'b1;
      if (w_err_set)    r_err    <= 1'b1;
    end
  end

  assign s_if.s_ready      = r_ready;
  assign weightValid       = r_wvld;
  assign biasValid         = r_bvld;
  assign weightValue       = r_wval;
  assign biasValue         = r_bval;
  assign config_layer_num  = r_layer;
  assign config_neuron_num = r_neuron;
  assign done              = r_done;
  assign loaded            = r_loaded;
  assign err               = r_err;
  assign weight_count      = r_wcount;

endmodule

// File: tb/tb_weight_config_loader.sv
// Directed bench for weight_config_loader: drives words #1 after each rising edge, checks outputs there too.
module tb_weight_config_loader;

  logic        clk;
  logic        rst;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        done;
  logic        loaded;
  logic        err;
  logic [31:0] weight_count;

  int n_checks;
  int n_errors;
  int w_seen;
  int b_seen;

  weight_config_loader_if s_if();

  weight_config_loader dut (
    .clk               (clk),
    .rst               (rst),
    .s_if              (s_if),
    .weightValid       (weightValid),
    .biasValid         (biasValid),
    .weightValue       (weightValue),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .done              (done),
    .loaded            (loaded),
    .err               (err),
    .weight_count      (weight_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one word for one edge, then settle and tally strobes seen.
  task automatic step(input logic vld, input logic [31:0] dat);
    s_if.s_valid = vld;
    s_if.s_data  = dat;
    @(posedge clk);
    #1;
    s_if.s_valid = 1'b0;
    if (weightValid) w_seen++;
    if (biasValid)   b_seen++;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    w_seen   = 0;
    b_seen   = 0;
    rst          = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;

    // Reset state
    step(0, 0);
    step(0, 0);
    chk("rst_ready",  32'(s_if.s_ready), 0);
    chk("rst_wvld",   32'(weightValid), 0);
    chk("rst_bvld",   32'(biasValid), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_err",    32'(err), 0);
    chk("rst_wcnt",   weight_count, 0);
    chk("rst_layer",  config_layer_num, 0);
    chk("rst_wval",   weightValue, 0);
    rst = 1'b1;
    step(0, 0);
    chk("ready_after_rst", 32'(s_if.s_ready), 1);

    // Weight packet: layer 1, neuron 2, three words
    step(1, 32'h0100_8003);
    chk("w_hdr_layer",  config_layer_num, 1);
    chk("w_hdr_neuron", config_neuron_num, 2);
    chk("w_hdr_nostb",  32'(weightValid), 0);
    step(1, 32'h0000_0100);
    chk("w0_vld", 32'(weightValid), 1);
    chk("w0_val", weightValue, 32'h100);
    chk("w0_done", 32'(done), 0);
    step(1, 32'h0000_0200);
    chk("w1_vld", 32'(weightValid), 1);
    chk("w1_val", weightValue, 32'h200);
    step(1, 32'h0000_FF00);
    chk("w2_vld",  32'(weightValid), 1);
    chk("w2_val",  weightValue, 32'hFF00);
    chk("w2_done", 32'(done), 1);
    chk("w2_cnt",  weight_count, 3);
    step(0, 0);
    chk("w_after_vld",  32'(weightValid), 0);
    chk("w_after_done", 32'(done), 0);

    // Bias packet: layer 0, neuron 5
    step(1, 32'h4001_4000);
    chk("b_hdr_layer",  config_layer_num, 0);
    chk("b_hdr_neuron", config_neuron_num, 5);
    step(1, 32'h0000_0080);
    chk("b_vld",   32'(biasValid), 1);
    chk("b_val",   biasValue, 32'h80);
    chk("b_done",  32'(done), 1);
    chk("b_nowv",  32'(weightValid), 0);
    chk("b_wcnt",  weight_count, 3);
    chk("b_whold", weightValue, 32'hFF00);

    // Weight count 4 with valid gaps: layer 2, neuron 3
    w_seen = 0;
    b_seen = 0;
    step(1, 32'h0200_C004);
    chk("g_layer",  config_layer_num, 2);
    chk("g_neuron", config_neuron_num, 3);
    step(1, 32'hA000_0001);
    step(0, 0);
    chk("g_gap_nostb", 32'(weightValid), 0);
    step(0, 0);
    step(1, 32'hA000_0002);
    step(0, 0);
    step(0, 0);
    chk("g_gap_hold", weightValue, 32'hA000_0002);
    step(1, 32'hA000_0003);
    chk("g_mid_done", 32'(done), 0);
    step(1, 32'hA000_0004);
    chk("g_last_val",  weightValue, 32'hA000_0004);
    chk("g_last_done", 32'(done), 1);
    step(0, 0);
    step(0, 0);
    chk("g_wstrobes", 32'(w_seen), 4);
    chk("g_bstrobes", 32'(b_seen), 0);
    chk("g_wcnt", weight_count, 7);

    // Zero-count weight header
    step(1, 32'h0000_0000);
    chk("z_done",   32'(done), 1);
    chk("z_nostb",  32'(weightValid), 0);
    chk("z_ready",  32'(s_if.s_ready), 1);
    chk("z_layer",  config_layer_num, 0);
    chk("z_neuron", config_neuron_num, 0);
    step(0, 0);
    chk("z_done_off", 32'(done), 0);

    // Reserved type then reset
    w_seen = 0;
    b_seen = 0;
    step(1, 32'hC000_0000);
    chk("e_err",   32'(err), 1);
    chk("e_ready", 32'(s_if.s_ready), 0);
    chk("e_done",  32'(done), 0);
    step(1, 32'h0000_0001);
    step(1, 32'h1234_5678);
    chk("e_nostb", 32'(w_seen + b_seen), 0);
    chk("e_sticky", 32'(err), 1);
    chk("e_wcnt",  weight_count, 7);
    rst = 1'b0;
    step(0, 0);
    chk("e_rst_err", 32'(err), 0);
    rst = 1'b1;
    step(0, 0);
    chk("e_rst_ready", 32'(s_if.s_ready), 1);

    // End-of-load
    step(1, 32'h8000_0000);
    chk("l_loaded", 32'(loaded), 1);
    chk("l_done",   32'(done), 1);
    chk("l_ready",  32'(s_if.s_ready), 0);
    step(1, 32'h0000_0000);
    chk("l_done_off", 32'(done), 0);
    chk("l_ready_hold", 32'(s_if.s_ready), 0);
    chk("l_loaded_hold", 32'(loaded), 1);

    // Reset mid-packet
    rst = 1'b0;
    step(0, 0);
    chk("m_rst_loaded", 32'(loaded), 0);
    rst = 1'b1;
    step(0, 0);
    step(1, 32'h0100_8003);
    step(1, 32'h0000_0111);
    chk("m_w0_vld", 32'(weightValid), 1);
    chk("m_w0_val", weightValue, 32'h111);
    rst = 1'b0;
    step(1, 32'h0000_0222);
    chk("m_rst_nostb", 32'(weightValid), 0);
    chk("m_rst_wcnt",  weight_count, 0);
    rst = 1'b1;
    w_seen = 0;
    b_seen = 0;
    step(0, 0);
    step(1, 32'h4001_4000);
    chk("m_hdr_nostb",  32'(w_seen + b_seen), 0);
    chk("m_hdr_neuron", config_neuron_num, 5);
    chk("m_hdr_layer",  config_layer_num, 0);
    step(1, 32'h0000_0055);
    chk("m_b_vld", 32'(biasValid), 1);
    chk("m_b_val", biasValue, 32'h55);
    chk("m_b_nowv", 32'(weightValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
